// File: rtl/motor_drive_pkg.sv
// Shared encodings and helpers for the motor_drive actuator stage.
package motor_drive_pkg;

  // FSM state encodings, also visible on state_o
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  // Direction field dir_cmd_i[1:0]; 00/11 mean stop
  localparam logic [1:0] DIR_FWD = 2'b01;
  localparam logic [1:0] DIR_REV = 2'b10;

  // Steering field dir_cmd_i[3:2]; 00/11 mean straight
  localparam logic [1:0] STEER_LEFT  = 2'b01;
  localparam logic [1:0] STEER_RIGHT = 2'b10;

  // Speed ceiling while exactly one TMR module is flagged faulty
  localparam logic [3:0] DEGRADED_CAP = 4'd8;

  // Number of faulty modules that forces the latched safe stop
  localparam int FAULT_MIN = 2;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/motor_drive_pwm_channel.sv
// One H-bridge channel: level-vs-counter compare, direction gating and
// the registered a/b bridge outputs.
module pwm_channel
  import motor_drive_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [3:0]          level,
  input  logic [1:0]          dir,
  input  logic                run_en,
  output logic                a,
  output logic                b
);

  logic pwm;

  // pwm_cnt < (level << (PWM_BITS-4)) reduces to comparing the top nibble,
  // because the shifted threshold has all-zero low bits. Level 15 is full on.
  assign pwm = (level == 4'hF) || (pwm_cnt[PWM_BITS-1 -: 4] < level);

  // Register the gated bridge drives; a and b are mutually exclusive via dir
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= 1'b0;
      b <= 1'b0;
    end else begin
      a <= pwm && (dir == DIR_FWD) && run_en;
      b <= pwm && (dir == DIR_REV) && run_en;
    end
  end

endmodule

// File: rtl/motor_drive.sv
// Differential-drive actuator stage: ramped level, dead-time on reversal,
// degraded speed cap on one faulty module, latched safe stop on two or more.
module motor_drive
  import motor_drive_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 16,
  parameter int DEAD_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] speed_cmd_i,
  input  logic [3:0] dir_cmd_i,
  input  logic [2:0] fault_i,
  output logic       l_a_o,
  output logic       l_b_o,
  output logic       r_a_o,
  output logic       r_b_o,
  output logic [3:0] lvl_o,
  output logic [1:0] state_o
);

  localparam int PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(RAMP_DIV - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEAD_CYC - 1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PS_W-1:0]     presc;
  logic [DC_W-1:0]     dead_cnt;
  logic [1:0]          state;
  logic [1:0]          dir_q;
  logic [3:0]          lvl;

  logic [1:0] n_fault;
  logic       fault_hard;
  logic       fault_soft;
  logic       tick;
  logic [1:0] cmd_dir;
  logic [1:0] steer;
  logic       cmd_valid;
  logic       cmd_opp;
  logic [3:0] target_raw;
  logic [3:0] target;
  logic [3:0] lvl_l;
  logic [3:0] lvl_r;
  logic       run_en;

  assign cmd_dir    = dir_cmd_i[1:0];
  assign steer      = dir_cmd_i[3:2];
  assign n_fault    = popcount3(fault_i);
  assign fault_hard = (32'(n_fault) >= FAULT_MIN);
  assign fault_soft = (n_fault == 2'd1);
  assign tick       = (presc == PS_LAST);
  assign cmd_valid  = (cmd_dir == DIR_FWD) || (cmd_dir == DIR_REV);
  assign cmd_opp    = cmd_valid && (cmd_dir != dir_q);

  // A command in the other direction ramps down to 0 before any reversal
  assign target_raw = (cmd_dir == dir_q) ? speed_cmd_i : 4'd0;
  assign target     = (fault_soft && (target_raw > DEGRADED_CAP)) ? DEGRADED_CAP : target_raw;

  // The inner wheel of a turn runs at half level
  assign lvl_l = (steer == STEER_LEFT)  ? (lvl >> 1) : lvl;
  assign lvl_r = (steer == STEER_RIGHT) ? (lvl >> 1) : lvl;

  // Fault is folded in combinationally so the sampling edge already drives low
  assign run_en = (state == ST_RUN) && !fault_hard;

  assign lvl_o   = lvl;
  assign state_o = state;

  // Free-running PWM counter and ramp prescaler, independent of the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      presc   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      presc   <= tick ? '0 : presc + 1'b1;
    end
  end

  // Drive FSM with level ramp; a hard fault overrides every other transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dir_q    <= DIR_FWD;
      lvl      <= 4'd0;
      dead_cnt <= '0;
    end else if (fault_hard) begin
      state    <= ST_FAULT;
      lvl      <= 4'd0;
      dead_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          lvl <= 4'd0;
          if (cmd_valid && (speed_cmd_i != 4'd0)) begin
            dir_q <= cmd_dir;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if ((lvl == 4'd0) && !cmd_valid) begin
            state <= ST_IDLE;
          end else if ((lvl == 4'd0) && cmd_opp) begin
            state    <= ST_DEAD;
            dead_cnt <= '0;
          end else if (tick) begin
            if (lvl < target) begin
              lvl <= lvl + 4'd1;
            end else if (lvl > target) begin
              lvl <= lvl - 4'd1;
            end
          end
        end
        ST_DEAD: begin
          // Commands are ignored here; the reversal always completes
          if (dead_cnt == DC_LAST) begin
            dir_q <= ~dir_q;
            state <= ST_RUN;
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        ST_FAULT: begin
          lvl <= 4'd0;
          if (speed_cmd_i == 4'd0) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_left (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt),
    .level   (lvl_l),
    .dir     (dir_q),
    .run_en  (run_en),
    .a       (l_a_o),
    .b       (l_b_o)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_right (
    .clk     (clk),
    .rst     (rst),
    .pwm_cnt (pwm_cnt),
    .level   (lvl_r),
    .dir     (dir_q),
    .run_en  (run_en),
    .a       (r_a_o),
    .b       (r_b_o)
  );

endmodule

// File: doc/motor_drive.md
# motor_drive

Downstream actuator stage of the DTMR motor controller. Consumes the voted speed/direction commands and the fault vector from DTMR and drives two H-bridge motor channels (left/right, differential steering) with PWM. Enforces soft ramping, dead-time on direction reversal, a degraded speed cap on a single faulty module, and a latched safe stop when two or more modules are faulty.

## Interface
- PWM_BITS, 8, PWM counter width; multiple of 4, at least 4
- RAMP_DIV, 16, clock cycles per ramp tick; at least 1
- DEAD_CYC, 8, dead-time cycles with all bridge outputs low on reversal; at least 1
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- speed_cmd_i  in  4  voted speed level 0..15 (from DTMR speed_cmd_o)
- dir_cmd_i  in  4  [1:0]: 01 fwd, 10 rev, 00/11 stop; [3:2]: 01 left, 10 right, 00/11 straight
- fault_i  in  3  one bit per faulty TMR module (from DTMR fault)
- l_a_o, l_b_o  out  1 each  left bridge: a = forward PWM, b = reverse PWM
- r_a_o, r_b_o  out  1 each  right bridge, same encoding
- lvl_o  out  4  current ramped level
- state_o  out  2  IDLE=0, RUN=1, DEAD=2, FAULT=3

## Operation
- Free-running PWM_BITS counter pwm_cnt and ramp prescaler (0..RAMP_DIV-1). Tick is one cycle when the prescaler equals RAMP_DIV-1.
- Target: speed_cmd_i if cmd direction equals latched dir_q, else 0. If popcount(fault_i)==1, target capped at 8.
- On each tick, lvl steps by exactly 1 toward target. No change between ticks.
- Per-motor level: the turning-side motor uses lvl>>1 (left for 01, right for 10). The other motor uses lvl.
- PWM high iff motor level == 15, or pwm_cnt < (level << (PWM_BITS-4)).
- a = pwm & (dir_q==fwd) & state==RUN. b = pwm & (dir_q==rev) & state==RUN. a and b are never both high.
- IDLE: lvl=0. If cmd dir is fwd/rev and speed>0, latch dir_q and go to RUN.
- RUN: ramp as above.
  - lvl==0 with stop command: go to IDLE.
  - lvl==0 with opposite valid command: go to DEAD.
- DEAD: all outputs low for DEAD_CYC cycles. Then latch the new dir_q and go to RUN.
- FAULT: entered from any state when popcount(fault_i)>=2. Priority is over every other transition.
  - lvl is cleared and all outputs are held low.
  - Exits to IDLE only when popcount(fault_i)<2 and speed_cmd_i==0 are true in the same cycle.
- Inputs are synchronous to clk; no input synchronisers.

## Timing
- Reset: all bridge outputs 0, lvl_o=0, state_o=0, dir_q=fwd, both counters 0. Applies immediately and asynchronously, including mid-ramp or mid-DEAD.
- All outputs are registered. Bridge outputs reflect the pwm_cnt/lvl/state values of the previous cycle.
- Fault to outputs low: the edge that samples popcount>=2 also loads state=FAULT and clears the bridge registers. No ramp-down.
- Ramp latency: a level change of N takes N ticks, i.e. N*RAMP_DIV cycles after the first tick.
- Reversal: ramp-down, then DEAD_CYC cycles with all outputs low, then ramp-up in the new direction.
- A command change during DEAD is not sampled. The latched reversal completes first.
- pwm_cnt wraps at 2^PWM_BITS-1 to 0. The prescaler wraps independently. Neither counter is reset by state changes.

## Structure
- Shared package motor_drive_pkg:
  - state encodings
  - dir/steer encodings (FWD=2'b01, REV=2'b10, LEFT=2'b01, RIGHT=2'b10)
  - DEGRADED_CAP=4'd8
  - FAULT_MIN=2
- Sub-module pwm_channel: per-motor compare plus a/b gating and output registers, instantiated twice, sharing pwm_cnt.
- Top level holds the FSM, prescaler, ramp, pwm_cnt and the fault popcount.

## Test plan
All scenarios use PWM_BITS=8, RAMP_DIV=4, DEAD_CYC=8.
- Reset, then speed 8, dir 4'b0001 → lvl reaches 8 after 8 ticks (32 cycles); l_a/r_a high 128 of every 256 cycles; b outputs stay 0; state_o=1.
- From lvl 8 forward, dir 4'b0010 → lvl ramps to 0; state_o=2 with all outputs low for exactly 8 cycles; then state_o=1 with b outputs toggling and a outputs stuck 0.
- Speed 15, dir 4'b0101 → right a constant high; left level 7 gives high 112 of every 256 cycles.
- Speed 12, fault 3'b010 → lvl settles at 8. Then fault 3'b011 → next edge all outputs 0, state_o=3. Clear fault with speed 12 → stays FAULT. Set speed 0 → IDLE the next cycle.
- Fault 3'b101 during DEAD → FAULT on the next edge, and DEAD never completes.
- Assert rst mid-ramp at lvl 5 → outputs, lvl_o and state_o are 0 before the next clk edge. Then dir 4'b0000 after recovery → remains IDLE.
